// File: rtl/onchip_ram_pkg.sv
// Shared constants and helpers for the pipelined Avalon-MM on-chip RAM.
package onchip_ram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int unsigned byte_cnt(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Inferred byte-enabled single-port RAM with a registered read port.
module onchip_ram_core
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 40960,
  parameter int IDX_W  = 16
) (
  input  logic                          clk,
  input  logic                          i_wr_en,
  input  logic                          i_rd_en,
  input  logic [IDX_W-1:0]              i_idx,
  input  logic [byte_cnt(DATA_W)-1:0]   i_be,
  input  logic [DATA_W-1:0]             i_wdata,
  output logic [DATA_W-1:0]             o_rdata
);

  localparam int NB = byte_cnt(DATA_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Enables are only raised for in-range indices, so the array is never
  // addressed past DEPTH even when IDX_W spans more words.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_rd_en) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/onchip_ram_avmm_pipelined.sv
// Avalon-MM pipelined slave around onchip_ram_core: acceptance, range check,
// valid/error pipeline and optional second output stage.
module onchip_ram_avmm_pipelined
  import onchip_ram_pkg::*;
#(
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 16,
  parameter int    DEPTH        = 40960,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ADDR_W-1:0]           address,
  input  logic [byte_cnt(DATA_W)-1:0] byteenable,
  input  logic                        chipselect,
  input  logic                        read,
  input  logic                        write,
  input  logic [DATA_W-1:0]           writedata,
  input  logic                        clken,
  input  logic                        reset_req,
  input  logic                        freeze,
  output logic [DATA_W-1:0]           readdata,
  output logic                        readdatavalid,
  output logic [1:0]                  response,
  output logic                        waitrequest
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("onchip_ram_avmm_pipelined: READ_LATENCY must be 1 or 2");
  end
  if (longint'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
    $error("onchip_ram_avmm_pipelined: DEPTH exceeds 2**ADDR_W");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("onchip_ram_avmm_pipelined: DATA_W must be a multiple of 8");
  end

  logic              w_en, w_in_range, w_rd_acc, w_wr_acc;
  logic [DATA_W-1:0] w_rdata, w_data1, w_data_q;
  logic              w_vld_q, w_err_q;
  logic              r_vld1, r_err1;

  assign w_en       = clken & ~reset_req;
  assign w_in_range = ({1'b0, address} < DEPTH_L);
  // A simultaneous write wins; the read is dropped without a response.
  assign w_rd_acc   = w_en & chipselect & read & ~write;
  assign w_wr_acc   = w_en & chipselect & write & ~freeze & w_in_range;

  onchip_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_core (
    .clk     (clk),
    .i_wr_en (w_wr_acc),
    .i_rd_en (w_rd_acc & w_in_range),
    .i_idx   (address[IDX_W-1:0]),
    .i_be    (byteenable),
    .i_wdata (writedata),
    .o_rdata (w_rdata)
  );

  // Pipeline advances on clken alone so reset_req lets in-flight reads drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld1 <= 1'b0;
      r_err1 <= 1'b0;
    end else if (clken) begin
      r_vld1 <= w_rd_acc;
      r_err1 <= w_rd_acc & ~w_in_range;
    end
  end

  // RAM register has no reset; masking gives zero data on reset and on errors.
  assign w_data1 = (r_vld1 & ~r_err1) ? w_rdata : '0;

  if (READ_LATENCY == 2) begin : g_lat2
    logic              r_vld2, r_err2;
    logic [DATA_W-1:0] r_data2;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_vld2  <= 1'b0;
        r_err2  <= 1'b0;
        r_data2 <= '0;
      end else if (clken) begin
        r_vld2  <= r_vld1;
        r_err2  <= r_err1;
        r_data2 <= w_data1;
      end
    end
    assign w_vld_q  = r_vld2;
    assign w_err_q  = r_err2;
    assign w_data_q = r_data2;
  end else begin : g_lat1
    assign w_vld_q  = r_vld1;
    assign w_err_q  = r_err1;
    assign w_data_q = w_data1;
  end

  assign readdata      = w_data_q;
  assign readdatavalid = w_vld_q & clken;
  assign response      = w_err_q ? RESP_SLVERR : RESP_OKAY;
  assign waitrequest   = 1'b0;

endmodule

// File: tb/tb_onchip_ram_avmm_pipelined.sv
// Drives latency-1 and latency-2 instances in lockstep; reads are scored
// against queued expectations as each instance returns them.
module tb_onchip_ram_avmm_pipelined;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] address;
  logic [3:0]  byteenable;
  logic        chipselect, read, write, clken, reset_req, freeze;
  logic [31:0] writedata;
  logic [31:0] rd1, rd2;
  logic        rdv1, rdv2, wr1, wr2;
  logic [1:0]  resp1, resp2;

  always #5 clk = ~clk;

  onchip_ram_avmm_pipelined #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .freeze(freeze),
    .readdata(rd1), .readdatavalid(rdv1), .response(resp1), .waitrequest(wr1));

  onchip_ram_avmm_pipelined #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .freeze(freeze),
    .readdata(rd2), .readdatavalid(rdv2), .response(resp2), .waitrequest(wr2));

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
    int          due;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        frz;
    logic [31:0] ed;
    logic [1:0]  er;
  } vec_t;

  exp_t q1[$], q2[$];
  exp_t m1, m2;
  vec_t tbl[20];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every valid beat must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rdv1 !== 1'b0) begin
      n_vec++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL rl1_extra_beat got data=%h resp=%b want no beat", rd1, resp1);
      end else begin
        m1 = q1.pop_front();
        if (rdv1 !== 1'b1 || rd1 !== m1.d || resp1 !== m1.r || (m1.due >= 0 && cyc != m1.due)) begin
          n_bad++;
          $display("FAIL rl1_beat got data=%h resp=%b cyc=%0d want data=%h resp=%b cyc=%0d",
                   rd1, resp1, cyc, m1.d, m1.r, m1.due);
        end
      end
    end
    if (rdv2 !== 1'b0) begin
      n_vec++;
      if (q2.size() == 0) begin
        n_bad++;
        $display("FAIL rl2_extra_beat got data=%h resp=%b want no beat", rd2, resp2);
      end else begin
        m2 = q2.pop_front();
        if (rdv2 !== 1'b1 || rd2 !== m2.d || resp2 !== m2.r || (m2.due >= 0 && cyc != m2.due)) begin
          n_bad++;
          $display("FAIL rl2_beat got data=%h resp=%b cyc=%0d want data=%h resp=%b cyc=%0d",
                   rd2, resp2, cyc, m2.d, m2.r, m2.due);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input logic frz);
    chipselect = 1'b1; read = rd; write = wr; address = a;
    byteenable = be; writedata = wd; freeze = frz;
  endtask

  task automatic idle(input int n);
    chipselect = 1'b0; read = 1'b0; write = 1'b0; freeze = 1'b0;
    repeat (n) step();
  endtask

  // Called just before the acceptance edge; due is the cycle of the beat.
  task automatic expect_rd(input logic [31:0] d, input logic [1:0] r, input bit timed,
                           input bit to1, input bit to2);
    exp_t e;
    e.d = d; e.r = r;
    if (to1) begin e.due = timed ? cyc + 1 : -1; q1.push_back(e); end
    if (to2) begin e.due = timed ? cyc + 2 : -1; q2.push_back(e); end
  endtask

  task automatic chk_zero(input string nm);
    n_vec++;
    if (rd1 !== 32'h0 || rdv1 !== 1'b0 || resp1 !== 2'b00 || wr1 !== 1'b0) begin
      n_bad++;
      $display("FAIL %s rl1 got data=%h vld=%b resp=%b wait=%b want all zero", nm, rd1, rdv1, resp1, wr1);
    end
    n_vec++;
    if (rd2 !== 32'h0 || rdv2 !== 1'b0 || resp2 !== 2'b00 || wr2 !== 1'b0) begin
      n_bad++;
      $display("FAIL %s rl2 got data=%h vld=%b resp=%b wait=%b want all zero", nm, rd2, rdv2, resp2, wr2);
    end
  endtask

  initial begin
    //            rd    wr    addr       be    wdata          frz   exp data       exp resp
    tbl[0]  = '{1'b0, 1'b1, 16'd5,     4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        2'b00};
    tbl[1]  = '{1'b1, 1'b0, 16'd5,     4'hF, 32'h0,        1'b0, 32'hDEADBEEF, 2'b00};
    tbl[2]  = '{1'b0, 1'b1, 16'd5,     4'h5, 32'h11223344, 1'b0, 32'h0,        2'b00};
    tbl[3]  = '{1'b1, 1'b0, 16'd5,     4'hF, 32'h0,        1'b0, 32'hDE22BE44, 2'b00};
    tbl[4]  = '{1'b0, 1'b1, 16'd5,     4'hF, 32'hFFFFFFFF, 1'b1, 32'h0,        2'b00};
    tbl[5]  = '{1'b1, 1'b0, 16'd5,     4'hF, 32'h0,        1'b0, 32'hDE22BE44, 2'b00};
    tbl[6]  = '{1'b1, 1'b0, 16'd40960, 4'hF, 32'h0,        1'b0, 32'h0,        2'b10};
    tbl[7]  = '{1'b0, 1'b1, 16'd40960, 4'hF, 32'h12345678, 1'b0, 32'h0,        2'b00};
    tbl[8]  = '{1'b1, 1'b0, 16'd40960, 4'hF, 32'h0,        1'b0, 32'h0,        2'b10};
    tbl[9]  = '{1'b1, 1'b0, 16'd5,     4'hF, 32'h0,        1'b0, 32'hDE22BE44, 2'b00};
    tbl[10] = '{1'b1, 1'b1, 16'd6,     4'hF, 32'hCAFEF00D, 1'b0, 32'h0,        2'b00};
    tbl[11] = '{1'b1, 1'b0, 16'd6,     4'hF, 32'h0,        1'b0, 32'hCAFEF00D, 2'b00};
    for (int i = 0; i < 8; i++)
      tbl[12+i] = '{1'b0, 1'b1, 16'(i), 4'hF, 32'hA5A50000 + 32'(i), 1'b0, 32'h0, 2'b00};

    reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0; freeze = 1'b0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; byteenable = '0; writedata = '0;
    repeat (3) step();
    chk_zero("reset_state");
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].be, tbl[i].wd, tbl[i].frz);
      if (tbl[i].rd && !tbl[i].wr) expect_rd(tbl[i].ed, tbl[i].er, 1'b1, 1'b1, 1'b1);
      step();
    end
    idle(3);

    // Back-to-back burst with a 3-cycle clken hole after the fourth read.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'(i), 4'hF, 32'h0, 1'b0);
      expect_rd(32'hA5A50000 + 32'(i), 2'b00, 1'b0, 1'b1, 1'b1);
      step();
    end
    clken = 1'b0;
    drive(1'b1, 1'b0, 16'd4, 4'hF, 32'h0, 1'b0);
    repeat (3) step();
    clken = 1'b1;
    for (int i = 4; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'(i), 4'hF, 32'h0, 1'b0);
      expect_rd(32'hA5A50000 + 32'(i), 2'b00, 1'b0, 1'b1, 1'b1);
      step();
    end
    idle(4);

    // Reset with reads in flight: only the latency-1 copy of the first read escapes.
    drive(1'b1, 1'b0, 16'd1, 4'hF, 32'h0, 1'b0);
    expect_rd(32'hA5A50001, 2'b00, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 1'b0, 16'd2, 4'hF, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    chipselect = 1'b0; read = 1'b0;
    repeat (2) step();
    chk_zero("in_reset");
    reset_n = 1'b1;
    idle(4);
    chk_zero("after_reset");

    // reset_req blocks the new read but lets the previous one finish.
    drive(1'b1, 1'b0, 16'd3, 4'hF, 32'h0, 1'b0);
    expect_rd(32'hA5A50003, 2'b00, 1'b1, 1'b1, 1'b1);
    step();
    reset_req = 1'b1;
    drive(1'b1, 1'b0, 16'd4, 4'hF, 32'h0, 1'b0);
    step();
    reset_req = 1'b0;
    idle(5);

    n_vec++;
    if (q1.size() != 0) begin
      n_bad++;
      $display("FAIL rl1_missing_beats got %0d outstanding want 0", q1.size());
    end
    n_vec++;
    if (q2.size() != 0) begin
      n_bad++;
      $display("FAIL rl2_missing_beats got %0d outstanding want 0", q2.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
